// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

    localparam int         PC_W_DEF     = 8;
    localparam int         INSTR_W_DEF  = 16;
    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        HALTED
    } state_e;

endpackage

// File: rtl/fetch_seq.sv
// Fetch sequencer: drives the external pc register's D input, issues one
// instruction-memory read at a time and hands the word to the decoder.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_q,
    output logic [PC_W-1:0]    pc_d,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        pc_d    = pc_q;

        if (br_taken && state_q != HALTED)
            pc_d = br_target;
        else if (state_q == REQ && imem_ack)
            pc_d = pc_q + PC_W'(1);

        unique case (state_q)
            IDLE: state_d = halt ? HALTED : REQ;
            REQ: begin
                if (imem_ack) begin
                    // A redirect racing the ack squashes the word and refetches.
                    state_d = br_taken ? REQ : HOLD;
                    if (!br_taken) begin
                        instr_d = imem_data;
                        valid_d = 1'b1;
                    end
                end else if (br_taken) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (br_taken)
                    state_d = REQ;
                else if (instr_ready)
                    state_d = halt ? HALTED : REQ;
                if (br_taken || instr_ready)
                    valid_d = 1'b0;
            end
            DRAIN:   if (imem_ack) state_d = REQ;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        // Every entry into REQ (including REQ->REQ on ack) starts a new read.
        if (state_d == REQ && (state_q != REQ || imem_ack))
            addr_d = pc_d;

        if (!rst_n)
            pc_d = RESET_PC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: models the pc register and memory, scoreboards
// delivered instructions against the words acked without a redirect.
module tb_fetch_seq;

    logic        clk, rst_n;
    logic [7:0]  pc_q, pc_d, imem_addr, br_target;
    logic        imem_req, imem_ack, instr_valid, instr_ready, br_taken, halt;
    logic [15:0] imem_data, instr;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic prev_v = 1'b0;

    fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .pc_q(pc_q), .pc_d(pc_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
        .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External pc register, loaded every clock.
    always @(posedge clk) pc_q <= pc_d;

    function automatic logic [15:0] mem(input logic [7:0] a);
        return {~a, a} ^ 16'h5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address, ack after wt cycles.
    task automatic fetch_one(input int wt, input logic [7:0] ea);
        int n = 0;
        logic [7:0] nx;
        nx = ea + 8'd1;
        while (!imem_req && n < 10) begin tick(); n++; end
        chk("req_seen", imem_req, 1);
        chk("req_addr", imem_addr, ea);
        repeat (wt) begin
            tick();
            chk("addr_hold", imem_addr, ea);
            chk("req_hold", imem_req, 1);
            chk("valid_early", instr_valid, 0);
        end
        imem_ack = 1'b1;
        imem_data = mem(ea);
        #1;
        chk("pc_inc", pc_d, nx);
        exp_q.push_back(mem(ea));
        tick();
        imem_ack = 1'b0;
        chk("valid_ack1", instr_valid, 1);
    endtask

    always @(negedge clk) begin
        if (instr_valid && !prev_v) begin
            if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
            else chk("sb_instr", instr, exp_q.pop_front());
        end
        prev_v = instr_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b1;
        br_taken = 1'b0; br_target = '0; halt = 1'b0;
        tick(); tick();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc_d", pc_d, 8'h00);
        rst_n = 1'b1;

        // Sequential run, one wait cycle each
        fetch_one(1, 8'h00);
        fetch_one(1, 8'h01);
        fetch_one(1, 8'h02);

        // Redirect from HOLD to 0xFF, then wrap
        br_taken = 1'b1; br_target = 8'hFF;
        #1 chk("hold_br_pc_d", pc_d, 8'hFF);
        tick();
        br_taken = 1'b0;
        chk("hold_br_valid", instr_valid, 0);
        fetch_one(0, 8'hFF);

        // Backpressure
        instr_ready = 1'b0;
        #1;
        chk("bp_req", imem_req, 0);
        chk("bp_pc_d", pc_d, 8'h00);
        repeat (3) begin
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", instr, mem(8'hFF));
            chk("bp_req", imem_req, 0);
            chk("bp_pc_d", pc_d, 8'h00);
        end
        instr_ready = 1'b1;
        fetch_one(0, 8'h00);

        // Branch during REQ, ack two cycles later -> drain
        tick();
        chk("br_req_addr", imem_addr, 8'h01);
        br_taken = 1'b1; br_target = 8'h40;
        #1 chk("br_pc_d", pc_d, 8'h40);
        tick();
        br_taken = 1'b0;
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 8'h01);
        tick();
        chk("drain_req2", imem_req, 1);
        imem_ack = 1'b1; imem_data = mem(8'h01);
        #1 chk("drain_pc_d", pc_d, 8'h40);
        tick();
        imem_ack = 1'b0;
        chk("drain_valid", instr_valid, 0);
        chk("drain_next_req", imem_req, 1);
        fetch_one(0, 8'h40);

        // Branch together with ack
        tick();
        chk("sim_addr", imem_addr, 8'h41);
        imem_ack = 1'b1; imem_data = mem(8'h41); br_taken = 1'b1; br_target = 8'h10;
        #1 chk("sim_pc_d", pc_d, 8'h10);
        tick();
        imem_ack = 1'b0; br_taken = 1'b0;
        chk("sim_valid", instr_valid, 0);
        chk("sim_req", imem_req, 1);
        fetch_one(0, 8'h10);

        // Halt from HOLD, then redirect and ack are ignored
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
        br_taken = 1'b1; br_target = 8'h55; imem_ack = 1'b1;
        #1 chk("halt_pc_d", pc_d, 8'h11);
        tick();
        br_taken = 1'b0; imem_ack = 1'b0;
        chk("halt_req2", imem_req, 0);
        chk("halt_valid2", instr_valid, 0);
        chk("halt_pc_q", pc_q, 8'h11);

        // Reset, redirect out of IDLE, then reset mid-request
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; br_taken = 1'b1; br_target = 8'h33;
        tick();
        br_taken = 1'b0;
        chk("idle_br_addr", imem_addr, 8'h33);
        chk("idle_br_req", imem_req, 1);
        rst_n = 1'b0;
        #1 chk("rst_req_pc_d", pc_d, 8'h00);
        tick();
        chk("rst_req_req", imem_req, 0);
        chk("rst_req_valid", instr_valid, 0);
        rst_n = 1'b1; imem_ack = 1'b1; imem_data = 16'hDEAD;
        #1 chk("late_ack_pc_d", pc_d, 8'h00);
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", instr_valid, 0);
        fetch_one(0, 8'h00);

        tick(); tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
